// File: rtl/msg_deframer.sv
// msg_deframer: splits header-framed PipeInLast words into method-tagged payload beats with length checking
module msg_deframer #(
   parameter int width = 32,
   parameter int DEPTH = 4
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             in_enq__ENA,
   input  logic [width-1:0] in_enq_v,
   input  logic             in_enq_last,
   output logic             in_enq__RDY,
   output logic             out_enq__ENA,
   output logic [width-1:0] out_enq_v,
   output logic [15:0]      out_enq_method,
   output logic             out_enq_last,
   output logic             out_enq_empty,
   input  logic             out_enq__RDY,
   output logic             err_short,
   output logic             err_long,
   output logic [31:0]      msg_count,
   output logic [15:0]      err_count
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {HDR, PAYLOAD, DRAIN} state_t;
   typedef struct packed {
      logic [width-1:0] v;
      logic [15:0]      m;
      logic             l;
      logic             e;
   } beat_t;
   state_t        state, nstate;
   logic [15:0]   remaining, nrem, method, nmeth, hlen, hmeth;
   beat_t         mem [DEPTH];
   beat_t         pb, head;
   logic [AW-1:0] wr, rd;
   logic [AW:0]   cnt;
   logic          full, empty, xfer, pop, push, e_s, e_l, done;
   assign hlen = in_enq_v[15:0];
   assign hmeth = 16'(in_enq_v[width-1:16]);
   assign full = cnt == (AW+1)'(DEPTH);
   assign empty = cnt == '0;
   assign in_enq__RDY = nRST && (state == DRAIN || !full);
   assign xfer = in_enq__ENA && in_enq__RDY;
   assign pop = !empty && out_enq__RDY;
   assign head = empty ? '0 : mem[rd];
   assign out_enq__ENA = !empty;
   assign {out_enq_v, out_enq_method, out_enq_last, out_enq_empty} = head;
   always_comb begin
      nstate = state;
      nrem = remaining;
      nmeth = method;
      push = 1'b0;
      pb = '0;
      e_s = 1'b0;
      e_l = 1'b0;
      done = 1'b0;
      if (xfer) begin
         if (state == HDR) begin
            nmeth = hmeth;
            pb.m = hmeth;
            pb.l = 1'b1;
            pb.e = 1'b1;
            if (hlen == 16'd0) begin
               e_l = 1'b1;
               nstate = in_enq_last ? HDR : DRAIN;
            end else if (hlen == 16'd1) begin
               push = 1'b1;
               done = in_enq_last;
               e_l = !in_enq_last;
               nstate = in_enq_last ? HDR : DRAIN;
            end else if (in_enq_last) begin
               push = 1'b1;
               e_s = 1'b1;
            end else begin
               nrem = hlen - 16'd1;
               nstate = PAYLOAD;
            end
         end else if (state == PAYLOAD) begin
            push = 1'b1;
            pb.v = in_enq_v;
            pb.m = method;
            pb.l = in_enq_last || remaining == 16'd1;
            nrem = remaining - 16'd1;
            if (remaining == 16'd1) begin
               done = in_enq_last;
               e_l = !in_enq_last;
               nstate = in_enq_last ? HDR : DRAIN;
            end else if (in_enq_last) begin
               e_s = 1'b1;
               nstate = HDR;
            end
         end else if (in_enq_last) begin
            nstate = HDR;
         end
      end
   end
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= HDR;
         remaining <= '0;
         method <= '0;
         wr <= '0;
         rd <= '0;
         cnt <= '0;
         err_short <= 1'b0;
         err_long <= 1'b0;
         msg_count <= '0;
         err_count <= '0;
      end else begin
         state <= nstate;
         remaining <= nrem;
         method <= nmeth;
         wr <= wr + AW'(push);
         rd <= rd + AW'(pop);
         cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
         err_short <= e_s;
         err_long <= e_l;
         msg_count <= msg_count + 32'(done);
         err_count <= err_count + 16'((e_s || e_l) && err_count != 16'hFFFF);
      end
   end
   always_ff @(posedge CLK) begin
      if (push) mem[wr] <= pb;
   end
endmodule
